// File: rtl/lane_pkg.sv
// Shared defaults and types for the lane collector.
package lane_pkg;

    localparam int NUM_LANES   = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int COUNT_WIDTH = 16;
    localparam int LANE_IDX_W  = $clog2(NUM_LANES);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/lane_buffer.sv
// One-entry lane buffer: holds a single word until the arbiter drains it.
// Refill in the same cycle as a drain is allowed.
module lane_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  drain,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data
);

    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    assign in_ready = ~full_q | drain;
    assign full     = full_q;
    assign data     = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (drain) full_d = 1'b0;
        // A write wins over a drain so the lane stays full on refill.
        if (in_valid && in_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/lane_collector.sv
// Collects words from NUM_LANES one-entry buffers and serializes them
// with a round-robin arbiter; counts output transfers (saturating).
module lane_collector
    import lane_pkg::*;
#(
    parameter int NUM_LANES  = lane_pkg::NUM_LANES,
    parameter int DATA_WIDTH = lane_pkg::DATA_WIDTH,
    localparam int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_LANES-1:0]   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data [NUM_LANES],
    output logic [NUM_LANES-1:0]   in_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [IDX_W-1:0]       out_lane,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    logic [NUM_LANES-1:0]   full;
    logic [NUM_LANES-1:0]   drain;
    logic [NUM_LANES-1:0]   buf_ready;
    logic [DATA_WIDTH-1:0]  buf_data [NUM_LANES];

    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       lock_grant_q, lock_grant_d;
    logic                   lock_q, lock_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]       rr_grant, rr_idx, grant;
    logic                   rr_found;
    logic                   xfer;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[i]),
            .in_data  (in_data[i]),
            .in_ready (buf_ready[i]),
            .drain    (drain[i]),
            .full     (full[i]),
            .data     (buf_data[i])
        );
        assign drain[i] = xfer && (grant == IDX_W'(i));
    end

    // First full lane at or after ptr, wrapping.
    always_comb begin
        rr_grant = ptr_q;
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            rr_idx = ptr_q + IDX_W'(k);
            if (!rr_found && full[rr_idx]) begin
                rr_grant = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // A stalled grant stays pinned so a newly filled lane cannot jump ahead
    // of the word already presented downstream.
    assign grant     = lock_q ? lock_grant_q : rr_grant;
    assign out_valid = (|full) & ~rst;
    assign xfer      = out_valid & out_ready;
    assign out_data  = out_valid ? buf_data[grant] : '0;
    assign out_lane  = out_valid ? grant : '0;
    assign in_ready  = buf_ready | {NUM_LANES{rst}};
    assign xfer_count = cnt_q;

    always_comb begin
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        lock_d       = out_valid & ~out_ready;
        lock_grant_d = grant;
        if (xfer) begin
            ptr_d = grant + IDX_W'(1);
            if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            cnt_q        <= '0;
            lock_q       <= 1'b0;
            lock_grant_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            lock_q       <= lock_d;
            lock_grant_q <= lock_grant_d;
        end
    end

endmodule

// File: tb/tb_lane_collector.sv
// Bench for lane_collector: queue-free behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lane_collector;
    import lane_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [7:0]     in_data [N];
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [7:0]     out_data;
    lane_idx_t      out_lane;
    logic           out_ready = 1'b0;
    logic [15:0]    xfer_count;

    int tests = 0;
    int errors = 0;
    bit chk_en = 0;

    // model state
    bit       full_m [N];
    logic [7:0] data_m [N];
    int       ptr_m = 0;
    int       held_m = -1;
    int       cnt_m = 0;

    lane_collector #(.NUM_LANES(N), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_lane(out_lane), .out_ready(out_ready), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Lane currently presented: pinned while stalled, else round-robin from ptr.
    function automatic int pres_lane();
        if (held_m >= 0) return held_m;
        for (int k = 0; k < N; k++)
            if (full_m[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        bit xf;
        bit rdy [N];
        chk_en <= 1'b1;
        if (rst) begin
            for (int i = 0; i < N; i++) begin full_m[i] = 0; data_m[i] = 8'h00; end
            ptr_m = 0; held_m = -1; cnt_m = 0;
        end else begin
            g  = pres_lane();
            xf = (g >= 0) && out_ready;
            for (int i = 0; i < N; i++) rdy[i] = !full_m[i] || (xf && g == i);
            if (xf) begin
                full_m[g] = 0;
                ptr_m = (g + 1) % N;
                held_m = -1;
                if (cnt_m < 65535) cnt_m++;
            end else if (g >= 0) begin
                held_m = g;
            end
            for (int i = 0; i < N; i++)
                if (in_valid[i] && rdy[i]) begin full_m[i] = 1; data_m[i] = in_data[i]; end
        end
    end

    always @(negedge clk) begin
        int g;
        bit ev;
        logic [N-1:0] er;
        if (chk_en) begin
            g  = pres_lane();
            ev = !rst && (g >= 0);
            for (int i = 0; i < N; i++)
                er[i] = rst || !full_m[i] || (ev && out_ready && g == i);
            check("m_out_valid", {31'b0, out_valid}, {31'b0, ev});
            check("m_out_lane", {30'b0, out_lane}, ev ? g : 0);
            check("m_out_data", {24'b0, out_data}, ev ? {24'b0, data_m[g]} : 0);
            check("m_in_ready", {28'b0, in_ready}, {28'b0, er});
            check("m_xfer_count", {16'b0, xfer_count}, cnt_m);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; tick(); rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_data[i] = 8'h00;
        tick(); tick();
        // reset then idle
        neg();
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_in_ready", {28'b0, in_ready}, 4'hF);
        check("rst_out_lane", {30'b0, out_lane}, 0);
        rst = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            neg();
            check("idle_valid", {31'b0, out_valid}, 0);
            check("idle_ready", {28'b0, in_ready}, 4'hF);
            check("idle_count", {16'b0, xfer_count}, 0);
            tick();
        end

        // single word on lane 2
        out_ready = 1'b1; in_valid = 4'b0100; in_data[2] = 8'hA5;
        tick(); in_valid = '0;
        neg();
        check("one_valid", {31'b0, out_valid}, 1);
        check("one_data", {24'b0, out_data}, 32'hA5);
        check("one_lane", {30'b0, out_lane}, 2);
        tick(); neg();
        check("one_valid_after", {31'b0, out_valid}, 0);
        check("one_count", {16'b0, xfer_count}, 1);

        // all four lanes at once
        do_reset();
        for (int i = 0; i < N; i++) in_data[i] = 8'h10 + 8'(i);
        in_valid = 4'hF; tick(); in_valid = '0;
        for (int j = 0; j < N; j++) begin
            neg();
            check("all_lane", {30'b0, out_lane}, j);
            check("all_data", {24'b0, out_data}, 32'h10 + j);
            tick();
        end
        neg();
        check("all_done", {31'b0, out_valid}, 0);
        check("all_count", {16'b0, xfer_count}, 4);

        // stall with lanes 1 and 3, then lane 0 arrives mid-stall
        out_ready = 1'b0; in_valid = 4'b1010; in_data[1] = 8'h21; in_data[3] = 8'h23;
        tick(); in_valid = '0;
        for (int c = 0; c < 5; c++) begin
            neg();
            check("stall_lane", {30'b0, out_lane}, 1);
            check("stall_data", {24'b0, out_data}, 32'h21);
            check("stall_ready", {28'b0, in_ready}, 4'b0101);
            tick();
        end
        in_valid = 4'b0001; in_data[0] = 8'h20; tick(); in_valid = '0;
        neg();
        check("stall_frozen", {30'b0, out_lane}, 1);
        out_ready = 1'b1;
        check("rel_lane1", {30'b0, out_lane}, 1);
        tick(); neg();
        check("rel_lane3", {30'b0, out_lane}, 3);
        check("rel_data3", {24'b0, out_data}, 32'h23);
        tick(); neg();
        check("rel_lane0", {30'b0, out_lane}, 0);
        tick();

        // fairness with lane 0 continuously valid
        do_reset();
        in_valid = 4'b1001; in_data[0] = 8'h40; in_data[3] = 8'h33;
        tick(); in_valid = 4'b0001; in_data[0] = 8'h41;
        neg();
        check("fair_first", {30'b0, out_lane}, 0);
        check("fair_refill_ready", {31'b0, in_ready[0]}, 1);
        tick(); in_data[0] = 8'h42;
        neg();
        check("fair_lane3", {30'b0, out_lane}, 3);
        check("fair_data3", {24'b0, out_data}, 32'h33);
        tick(); in_valid = '0;
        neg();
        check("fair_back0", {30'b0, out_lane}, 0);
        check("fair_data0", {24'b0, out_data}, 32'h41);
        tick(); tick(); tick();

        // reset mid-stream
        out_ready = 1'b0; in_valid = 4'b0111; tick(); in_valid = '0;
        rst = 1'b1;
        neg();
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_ready", {28'b0, in_ready}, 4'hF);
        tick(); rst = 1'b0;
        neg();
        check("mid_after_valid", {31'b0, out_valid}, 0);
        check("mid_after_count", {16'b0, xfer_count}, 0);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) in_data[i] = 8'($urandom);
            rst = ($urandom_range(0, 127) == 0);
            tick();
        end
        rst = 1'b0; in_valid = '0; out_ready = 1'b1;
        tick(); tick(); tick(); tick(); tick();

        // saturation: one transfer per cycle for 70000 cycles
        do_reset();
        in_valid = 4'b0001;
        for (int c = 0; c < 70000; c++) begin
            in_data[0] = 8'(c);
            tick();
        end
        neg();
        check("sat_count", {16'b0, xfer_count}, 32'hFFFF);
        tick(); tick();
        neg();
        check("sat_hold", {16'b0, xfer_count}, 32'hFFFF);
        in_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
